// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, one access at a time
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_valid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_valid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_oe_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rdata_i
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    streak_q, streak_d;
    logic          rd_if_q, rd_if_d;
    logic          if_gnt_q, if_gnt_d, if_valid_q, if_valid_d;
    logic          d_gnt_q, d_gnt_d, d_valid_q, d_valid_d;
    logic          mem_oe_q, mem_oe_d, mem_we_q, mem_we_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, mem_wdata_q, mem_wdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          d_win;

    // data normally wins; two data grants in a row let a waiting fetch through
    assign d_win = d_req_i && !(streak_q == 2'd2 && if_req_i);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        rd_if_d     = rd_if_q;
        if_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        d_gnt_d     = 1'b0;
        d_valid_d   = 1'b0;
        mem_oe_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    d_gnt_d    = 1'b1;
                    mem_addr_d = d_addr_i;
                    streak_d   = streak_q == 2'd2 ? 2'd2 : streak_q + 2'd1;
                    state_d    = d_we_i ? WRITE : READ;
                    mem_we_d   = d_we_i;
                    mem_oe_d   = !d_we_i;
                    cnt_d      = d_we_i ? cnt_q : CW'(1);
                    rd_if_d    = 1'b0;
                    if (d_we_i) mem_wdata_d = d_wdata_i;
                end else if (if_req_i) begin
                    if_gnt_d   = 1'b1;
                    mem_addr_d = if_addr_i;
                    streak_d   = 2'd0;
                    state_d    = READ;
                    mem_oe_d   = 1'b1;
                    cnt_d      = CW'(1);
                    rd_if_d    = 1'b1;
                end
            end
            READ: begin
                if (cnt_q == CW'(MEM_LAT)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    if_valid_d = rd_if_q;
                    d_valid_d  = !rd_if_q;
                    if_rdata_d = rd_if_q ? mem_rdata_i : if_rdata_q;
                    d_rdata_d  = rd_if_q ? d_rdata_q : mem_rdata_i;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    mem_oe_d = 1'b1;
                end
            end
            WRITE: begin
                state_d   = IDLE;
                d_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            rd_if_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            d_gnt_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            rd_if_q     <= rd_if_d;
            if_gnt_q    <= if_gnt_d;
            if_valid_q  <= if_valid_d;
            d_gnt_q     <= d_gnt_d;
            d_valid_q   <= d_valid_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign if_valid_o  = if_valid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_gnt_o     = d_gnt_q;
    assign d_valid_o   = d_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_oe_o    = mem_oe_q;
    assign mem_we_o    = mem_we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 2 and 1) against a latency-aware memory and a transaction model
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req [2];
    logic [31:0] if_addr [2];
    logic        if_gnt [2];
    logic        if_valid [2];
    logic [31:0] if_rdata [2];
    logic        d_req [2];
    logic        d_we [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic        d_gnt [2];
    logic        d_valid [2];
    logic [31:0] d_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic        mem_oe [2];
    logic        mem_we [2];
    logic [31:0] mem_rdata [2];

    logic [31:0] mem_val [2][256];
    bit          mem_ok [2][256];
    int          oe_run [2];
    logic [31:0] ref_val [2][256];
    bit          ref_ok [2][256];
    int          streak_m [2];
    logic [31:0] exp_if [2];
    logic [31:0] exp_d [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(g == 0 ? 2 : 1)) u_dut (
            .clk_i(clk), .reset_i(rst),
            .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_gnt_o(if_gnt[g]),
            .if_valid_o(if_valid[g]), .if_rdata_o(if_rdata[g]),
            .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
            .d_gnt_o(d_gnt[g]), .d_valid_o(d_valid[g]), .d_rdata_o(d_rdata[g]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_oe_o(mem_oe[g]),
            .mem_we_o(mem_we[g]), .mem_rdata_i(mem_rdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return k == 0 ? 2 : 1;
    endfunction

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {8'hC0 ^ a[7:0], 8'hDE, 8'h00, a[15:8]};
    endfunction

    function automatic logic [31:0] ref_rd(input int k, input logic [31:0] a);
        return ref_ok[k][a[9:2]] ? ref_val[k][a[9:2]] : init_val(a);
    endfunction

    function automatic logic [133:0] outs(input int k);
        return {if_gnt[k], if_valid[k], d_gnt[k], d_valid[k], mem_oe[k], mem_we[k],
                if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]};
    endfunction

    // memory macro: read data only becomes valid once OE has been held for the latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            oe_run[k] <= mem_oe[k] ? oe_run[k] + 1 : 0;
            if (mem_we[k]) begin
                mem_val[k][mem_addr[k][9:2]] <= mem_wdata[k];
                mem_ok[k][mem_addr[k][9:2]]  <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = (mem_oe[k] && oe_run[k] >= lat_of(k) - 1)
                ? (mem_ok[k][mem_addr[k][9:2]] ? mem_val[k][mem_addr[k][9:2]] : init_val(mem_addr[k]))
                : 32'hBAD0BAD0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0;
            streak_m[k] = 0; exp_if[k] = '0; exp_d[k] = '0;
        end
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs(k) !== '0) begin errors++; $display("FAIL reset_state dut%0d got=%h exp=0", k, outs(k)); end
        end
        if_req[0] = 1'b1; if_addr[0] = 32'h200;
        tick;
        checks++;
        if (if_gnt[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt got=%b exp=1", if_gnt[0]); end
        if_req[0] = 1'b0;
        rst = 1'b1;
        repeat (3) begin
            tick;
            checks++;
            if (outs(0) !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", outs(0)); end
        end
        rst = 1'b0;
        repeat (3) begin
            tick;
            checks++;
            if (outs(0) !== '0) begin errors++; $display("FAIL reset_after got=%h exp=0", outs(0)); end
        end
    endtask

    task automatic test_fetch;
        apply_reset;
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        tick;
        checks++;
        if ({if_gnt[0], if_valid[0], mem_oe[0], mem_we[0], mem_addr[0]} !== {4'b1010, 32'h100}) begin
            errors++; $display("FAIL fetch_gnt got=%b%b%b%b addr=%h exp=1010 addr=100",
                              if_gnt[0], if_valid[0], mem_oe[0], mem_we[0], mem_addr[0]);
        end
        if_req[0] = 1'b0; if_addr[0] = 32'hFFFF_FFF0;
        tick;
        checks++;
        if ({if_gnt[0], if_valid[0], mem_oe[0], mem_addr[0]} !== {3'b001, 32'h100}) begin
            errors++; $display("FAIL fetch_wait got=%b%b%b addr=%h exp=001 addr=100",
                              if_gnt[0], if_valid[0], mem_oe[0], mem_addr[0]);
        end
        tick;
        checks++;
        if ({if_valid[0], mem_oe[0], if_rdata[0]} !== {2'b10, 32'hC0DE0001}) begin
            errors++; $display("FAIL fetch_valid got=%b%b data=%h exp=10 data=c0de0001",
                              if_valid[0], mem_oe[0], if_rdata[0]);
        end
        tick;
        checks++;
        if ({if_valid[0], if_rdata[0]} !== {1'b0, 32'hC0DE0001}) begin
            errors++; $display("FAIL fetch_hold got=%b data=%h exp=0 data=c0de0001", if_valid[0], if_rdata[0]);
        end
    endtask

    task automatic test_store;
        apply_reset;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEADBEEF;
        tick;
        checks++;
        if ({d_gnt[0], d_valid[0], mem_we[0], mem_oe[0], mem_addr[0], mem_wdata[0]} !==
            {4'b1010, 32'h40, 32'hDEADBEEF}) begin
            errors++; $display("FAIL store_gnt got=%b%b%b%b addr=%h wd=%h exp=1010 addr=40 wd=deadbeef",
                              d_gnt[0], d_valid[0], mem_we[0], mem_oe[0], mem_addr[0], mem_wdata[0]);
        end
        ref_val[0][8'h10] = 32'hDEADBEEF; ref_ok[0][8'h10] = 1'b1;
        d_req[0] = 1'b0; d_wdata[0] = 32'h12345678;
        tick;
        checks++;
        if ({d_gnt[0], d_valid[0], mem_we[0], mem_oe[0], d_rdata[0]} !== {4'b0100, 32'h0}) begin
            errors++; $display("FAIL store_valid got=%b%b%b%b rdata=%h exp=0100 rdata=0",
                              d_gnt[0], d_valid[0], mem_we[0], mem_oe[0], d_rdata[0]);
        end
        tick;
        checks++;
        if ({d_valid[0], mem_we[0]} !== 2'b00) begin
            errors++; $display("FAIL store_after got=%b%b exp=00", d_valid[0], mem_we[0]);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset;
        if_req[0] = 1'b1; if_addr[0] = 32'h104;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10;
        tick;
        checks++;
        if ({d_gnt[0], if_gnt[0]} !== 2'b10) begin
            errors++; $display("FAIL sim_first got d,if=%b%b exp=10", d_gnt[0], if_gnt[0]);
        end
        d_req[0] = 1'b0;
        tick;
        tick;
        checks++;
        if ({d_valid[0], if_gnt[0], d_rdata[0]} !== {2'b10, ref_rd(0, 32'h10)}) begin
            errors++; $display("FAIL sim_dvalid got=%b%b data=%h exp=10 data=%h",
                              d_valid[0], if_gnt[0], d_rdata[0], ref_rd(0, 32'h10));
        end
        tick;
        checks++;
        if ({if_gnt[0], d_valid[0], mem_addr[0]} !== {2'b10, 32'h104}) begin
            errors++; $display("FAIL sim_ifgnt got=%b%b addr=%h exp=10 addr=104", if_gnt[0], d_valid[0], mem_addr[0]);
        end
        if_req[0] = 1'b0;
        tick;
        tick;
        checks++;
        if ({if_valid[0], if_rdata[0]} !== {1'b1, ref_rd(0, 32'h104)}) begin
            errors++; $display("FAIL sim_ifvalid got=%b data=%h exp=1 data=%h", if_valid[0], if_rdata[0], ref_rd(0, 32'h104));
        end
    endtask

    task automatic test_starvation;
        logic [5:0] order;
        int         n;
        apply_reset;
        if_req[0] = 1'b1; if_addr[0] = 32'h108;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
        order = '0;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            tick;
            if (if_gnt[0]) begin order[n] = 1'b1; n++; end
            else if (d_gnt[0]) begin order[n] = 1'b0; n++; end
        end
        checks++;
        if (n != 6 || order !== 6'b100100) begin
            errors++; $display("FAIL starv_order got n=%0d order=%b exp n=6 order=100100", n, order);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h10;
        tick;
        checks++;
        if ({d_gnt[1], mem_oe[1], mem_addr[1]} !== {2'b11, 32'h10}) begin
            errors++; $display("FAIL b2b_gnt1 got=%b%b addr=%h exp=11 addr=10", d_gnt[1], mem_oe[1], mem_addr[1]);
        end
        d_addr[1] = 32'h14;
        tick;
        checks++;
        if ({d_gnt[1], d_valid[1], d_rdata[1]} !== {2'b01, ref_rd(1, 32'h10)}) begin
            errors++; $display("FAIL b2b_valid1 got=%b%b data=%h exp=01 data=%h", d_gnt[1], d_valid[1], d_rdata[1], ref_rd(1, 32'h10));
        end
        tick;
        checks++;
        if ({d_gnt[1], d_valid[1], mem_oe[1], mem_addr[1]} !== {3'b101, 32'h14}) begin
            errors++; $display("FAIL b2b_gnt2 got=%b%b%b addr=%h exp=101 addr=14", d_gnt[1], d_valid[1], mem_oe[1], mem_addr[1]);
        end
        d_req[1] = 1'b0;
        tick;
        checks++;
        if ({d_valid[1], d_rdata[1]} !== {1'b1, ref_rd(1, 32'h14)}) begin
            errors++; $display("FAIL b2b_valid2 got=%b data=%h exp=1 data=%h", d_valid[1], d_rdata[1], ref_rd(1, 32'h14));
        end
    endtask

    // transaction model: pending set and grant history decide the winner; latency depends only on op type
    task automatic test_random(input int k);
        bit          pif, pd, we, win_d, ev_if, ev_d;
        logic [31:0] ia, da, wd, ea;
        int          lat;
        apply_reset;
        for (int r = 0; r < 40; r++) begin
            pif = 1'($urandom_range(0, 1));
            pd  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            ia  = 32'($urandom_range(0, 255)) << 2;
            da  = 32'($urandom_range(0, 255)) << 2;
            wd  = $urandom;
            if_req[k] = pif; if_addr[k] = ia;
            d_req[k] = pd; d_we[k] = we; d_addr[k] = da; d_wdata[k] = wd;
            while (pif || pd) begin
                win_d = pd && !(streak_m[k] == 2 && pif);
                ea = win_d ? da : ia;
                tick;
                checks++;
                if ({if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k], mem_addr[k]} !== {!win_d, win_d, !(win_d && we), win_d && we, ea}
                    || (win_d && we && mem_wdata[k] !== wd)) begin
                    errors++; $display("FAIL rnd_gnt dut%0d got if,d,oe,we=%b%b%b%b addr=%h wd=%h exp=%b%b%b%b addr=%h wd=%h",
                                      k, if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k], mem_addr[k], mem_wdata[k],
                                      !win_d, win_d, !(win_d && we), win_d && we, ea, wd);
                end
                streak_m[k] = win_d ? (streak_m[k] == 2 ? 2 : streak_m[k] + 1) : 0;
                if (win_d) begin
                    d_req[k] = 1'b0; pd = 1'b0; d_addr[k] = $urandom; d_wdata[k] = $urandom;
                end else begin
                    if_req[k] = 1'b0; pif = 1'b0; if_addr[k] = $urandom;
                end
                lat = (win_d && we) ? 2 : lat_of(k) + 1;
                for (int j = 1; j < lat - 1; j++) begin
                    tick;
                    checks++;
                    if ({if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k]} !== 6'b000010) begin
                        errors++; $display("FAIL rnd_wait dut%0d got v,g,oe,we=%b%b%b%b%b%b exp=000010",
                                          k, if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k]);
                    end
                end
                if (win_d && we) begin
                    ref_val[k][da[9:2]] = wd; ref_ok[k][da[9:2]] = 1'b1;
                end else if (win_d) exp_d[k] = ref_rd(k, da);
                else exp_if[k] = ref_rd(k, ia);
                ev_if = !win_d;
                ev_d  = win_d;
                tick;
                checks++;
                if ({if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k], if_rdata[k], d_rdata[k]} !==
                    {ev_if, ev_d, 4'b0000, exp_if[k], exp_d[k]}) begin
                    errors++; $display("FAIL rnd_valid dut%0d got v,g,oe,we=%b%b%b%b%b%b ifd=%h dd=%h exp=%b%b0000 ifd=%h dd=%h",
                                      k, if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k],
                                      if_rdata[k], d_rdata[k], ev_if, ev_d, exp_if[k], exp_d[k]);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                tick;
                checks++;
                if ({if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k]} !== 6'b0) begin
                    errors++; $display("FAIL rnd_idle dut%0d got v,g,oe,we=%b%b%b%b%b%b exp=000000",
                                      k, if_valid[k], d_valid[k], if_gnt[k], d_gnt[k], mem_oe[k], mem_we[k]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        test_reset;
        test_fetch;
        test_store;
        test_simultaneous;
        test_starvation;
        test_back_to_back;
        test_random(0);
        test_random(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
